// File: rtl/emif_dir_ctrl.sv
// emif_dir_ctrl -- EMIF data-bus direction controller.
//
// Watches CH_NUM active-low access strobes from the MCU, opens a hold window
// per access and drives the FPGA output enable while the MCU reads. After each
// window the bus is forcibly released for TURN_CYC cycles. An access arriving
// during the turnaround is held as pending and served right after it.
// Conflicting accesses raise a one-cycle overlap_err pulse.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ce_n         per-channel access strobes, active low, asynchronous
//   ch_en        channel enable mask
//   we_logic     high = MCU read (FPGA drives), asynchronous
//   setout       FPGA drives emif_data
//   data_oe      per-pin registered replica of setout
//   ch_sel       one-hot owner of the current window, 0 when idle
//   busy         controller not idle
//   overlap_err  one-cycle pulse on a conflicting access
//   stat_clr     (EMIF_DIR_STAT_EN only) clear rd_cnt
//   rd_cnt       (EMIF_DIR_STAT_EN only) saturating count of setout rises
//
// Optional feature macro: EMIF_DIR_STAT_EN (read-access statistics counter).

module emif_dir_ctrl #(
   parameter int unsigned CH_NUM      = 2,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned HOLD_CYC    = 23,
   parameter int unsigned TURN_CYC    = 2,
   parameter int unsigned DW          = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CH_NUM-1:0] ce_n,
   input  logic [CH_NUM-1:0] ch_en,
   input  logic              we_logic,
`ifdef EMIF_DIR_STAT_EN
   input  logic              stat_clr,
   output logic [15:0]       rd_cnt,
`endif
   output logic              setout,
   output logic [DW-1:0]     data_oe,
   output logic [CH_NUM-1:0] ch_sel,
   output logic              busy,
   output logic              overlap_err
);

   typedef enum logic [1:0] {StIdle, StActive, StTurn} state_e;

   // Synchronisers: ce_n idles high, we_logic idles low, so reset creates no edge.
   logic [SYNC_STAGES-1:0][CH_NUM-1:0] ce_sync_q;
   logic [CH_NUM-1:0]                  ce_dly_q;
   logic [SYNC_STAGES-1:0]             we_sync_q;
   logic [CH_NUM-1:0]                  ce_last;
   logic                               we_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ce_sync_q <= '1;
         ce_dly_q  <= '1;
         we_sync_q <= '0;
      end else begin
         ce_sync_q <= {ce_sync_q[SYNC_STAGES-2:0], ce_n};
         ce_dly_q  <= ce_sync_q[SYNC_STAGES-1];
         we_sync_q <= {we_sync_q[SYNC_STAGES-2:0], we_logic};
      end
   end

   assign ce_last = ce_sync_q[SYNC_STAGES-1];
   assign we_sync = we_sync_q[SYNC_STAGES-1];

   // Enabled falling edges and the lowest-index winner among them.
   logic [CH_NUM-1:0] fall;
   logic [CH_NUM-1:0] win;

   assign fall = ~ce_last & ce_dly_q & ch_en;

   always_comb begin
      win = '0;
      for (int i = 0; i < CH_NUM; i++) begin
         if (fall[i] && (win == '0)) win[i] = 1'b1;
      end
   end

   // FSM state and datapath registers.
   state_e            state_q, state_d;
   logic [CH_NUM-1:0] owner_q, owner_d;
   logic [CH_NUM-1:0] pend_q, pend_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [3:0]        tcnt_q, tcnt_d;
   logic              setout_d;
   logic              ovl_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         owner_q     <= '0;
         pend_q      <= '0;
         cnt_q       <= '0;
         tcnt_q      <= '0;
         setout      <= 1'b0;
         data_oe     <= '0;
         overlap_err <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         pend_q      <= pend_d;
         cnt_q       <= cnt_d;
         tcnt_q      <= tcnt_d;
         setout      <= setout_d;
         data_oe     <= {DW{setout_d}};
         overlap_err <= ovl_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      tcnt_d  = tcnt_q;
      unique case (state_q)
         StIdle: begin
            if (|fall) begin
               state_d = StActive;
               owner_d = win;
               cnt_d   = 8'd1;
            end
         end
         StActive: begin
            // Retrigger takes priority over window expiry.
            if (|(fall & owner_q)) begin
               cnt_d = 8'd1;
            end else if (cnt_q == 8'(HOLD_CYC)) begin
               state_d = StTurn;
               tcnt_d  = 4'd1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         StTurn: begin
            if ((pend_q == '0) && (|fall)) pend_d = win;
            // An edge captured on the final turnaround cycle is served directly.
            if (tcnt_q == 4'(TURN_CYC)) begin
               if (|pend_d) begin
                  state_d = StActive;
                  owner_d = pend_d;
                  cnt_d   = 8'd1;
                  pend_d  = '0;
               end else begin
                  state_d = StIdle;
                  owner_d = '0;
               end
            end else begin
               tcnt_d = tcnt_q + 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      setout_d = (state_q == StActive) & we_sync;
      ovl_d    = 1'b0;
      unique case (state_q)
         StActive: ovl_d = |(fall & ~owner_q);
         StTurn:   ovl_d = (pend_q != '0) && (|fall);
         default:  ovl_d = 1'b0;
      endcase
   end

   assign ch_sel = (state_q == StIdle) ? '0 : owner_q;
   assign busy   = (state_q != StIdle);

`ifdef EMIF_DIR_STAT_EN
   logic [15:0] rd_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt_q <= '0;
      end else if (stat_clr) begin
         rd_cnt_q <= '0;
      end else if (setout_d && !setout && (rd_cnt_q != 16'hFFFF)) begin
         rd_cnt_q <= rd_cnt_q + 16'd1;
      end
   end

   assign rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_emif_dir_ctrl.sv
// tb_emif_dir_ctrl -- directed self-checking bench for emif_dir_ctrl with
// default parameters. Edge numbering: edge 1 is the first rising edge that
// samples the new ce_n value; outputs are sampled 1 ns after each edge.

module tb_emif_dir_ctrl;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1:0]    ce_n = 2'b11;
   logic [1:0]    ch_en = 2'b11;
   logic          we_logic = 1'b0;
   logic          setout;
   logic [DW-1:0] data_oe;
   logic [1:0]    ch_sel;
   logic          busy;
   logic          overlap_err;
`ifdef EMIF_DIR_STAT_EN
   logic          stat_clr = 1'b0;
   logic [15:0]   rd_cnt;
`endif

   emif_dir_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ce_n        (ce_n),
      .ch_en       (ch_en),
      .we_logic    (we_logic),
`ifdef EMIF_DIR_STAT_EN
      .stat_clr    (stat_clr),
      .rd_cnt      (rd_cnt),
`endif
      .setout      (setout),
      .data_oe     (data_oe),
      .ch_sel      (ch_sel),
      .busy        (busy),
      .overlap_err (overlap_err)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Per-window statistics gathered by observe().
   int         rise_edge;
   int         set_cnt;
   int         busy_cnt;
   int         ovl_cnt;
   int         oe_bad;
   logic [1:0] sel_or;
   logic [1:0] log_sel [0:79];

   task automatic check(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Run ncyc edges, collecting stats; apply up to two ce_n changes after edges e1_at/e2_at.
   task automatic observe(input int ncyc, input int e1_at, input logic [1:0] e1_ce,
                          input int e2_at, input logic [1:0] e2_ce);
      rise_edge = -1;
      set_cnt   = 0;
      busy_cnt  = 0;
      ovl_cnt   = 0;
      oe_bad    = 0;
      sel_or    = '0;
      for (int i = 1; i <= ncyc; i++) begin
         @(posedge clk);
         #1;
         if (setout && rise_edge < 0) rise_edge = i;
         set_cnt  += int'(setout);
         busy_cnt += int'(busy);
         ovl_cnt  += int'(overlap_err);
         if (data_oe !== {DW{setout}}) oe_bad++;
         sel_or |= ch_sel;
         log_sel[i] = ch_sel;
         if (i == e1_at) ce_n = e1_ce;
         if (i == e2_at) ce_n = e2_ce;
      end
   endtask

   initial begin
      // Reset state
      tick(2);
      check("rst_setout", int'(setout), 0);
      check("rst_data_oe", int'(data_oe), 0);
      check("rst_ch_sel", int'(ch_sel), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_ovl", int'(overlap_err), 0);
      rst_n    = 1'b1;
      we_logic = 1'b1;
      tick(5);

      // 1: read access on ch0
      ce_n = 2'b10;
      observe(35, 5, 2'b11, 0, 2'b11);
      check("t1_rise_edge", rise_edge, 4);
      check("t1_setout_cyc", set_cnt, 23);
      check("t1_busy_cyc", busy_cnt, 25);
      check("t1_oe_match", oe_bad, 0);
      check("t1_ch_sel", int'(sel_or), 1);
      check("t1_ovl", ovl_cnt, 0);
      check("t1_idle_end", int'(busy), 0);
      tick(4);

      // 2: write access on ch1, FPGA must not drive
      we_logic = 1'b0;
      tick(4);
      ce_n = 2'b01;
      observe(35, 5, 2'b11, 0, 2'b11);
      check("t2_rise_edge", rise_edge, -1);
      check("t2_setout_cyc", set_cnt, 0);
      check("t2_busy_cyc", busy_cnt, 25);
      check("t2_ch_sel", int'(sel_or), 2);
      we_logic = 1'b1;
      tick(4);

      // 3: ch0 retrigger 10 cycles into its window
      ce_n = 2'b10;
      observe(45, 5, 2'b11, 10, 2'b10);
      check("t3_rise_edge", rise_edge, 4);
      check("t3_setout_cyc", set_cnt, 33);
      check("t3_busy_cyc", busy_cnt, 35);
      check("t3_ovl", ovl_cnt, 0);
      ce_n = 2'b11;
      tick(4);

      // 4a: ch1 during ch0 ACTIVE
      ce_n = 2'b10;
      observe(35, 5, 2'b11, 8, 2'b01);
      check("t4a_ovl_pulse", ovl_cnt, 1);
      check("t4a_setout_cyc", set_cnt, 23);
      check("t4a_busy_cyc", busy_cnt, 25);
      check("t4a_ch_sel", int'(sel_or), 1);
      ce_n = 2'b11;
      tick(4);

      // 4b: ch1 during ch0 TURN -> served right after turnaround
      ce_n = 2'b10;
      observe(60, 5, 2'b11, 24, 2'b01);
      check("t4b_sel_turn", int'(log_sel[27]), 1);
      check("t4b_sel_next", int'(log_sel[28]), 2);
      check("t4b_setout_cyc", set_cnt, 46);
      check("t4b_busy_cyc", busy_cnt, 50);
      check("t4b_ovl", ovl_cnt, 0);
      ce_n = 2'b11;
      tick(4);

      // 5a: simultaneous edges with ch0 masked
      ch_en = 2'b10;
      ce_n  = 2'b00;
      observe(35, 5, 2'b11, 0, 2'b11);
      check("t5a_ch_sel", int'(sel_or), 2);
      check("t5a_ovl", ovl_cnt, 0);
      check("t5a_busy_cyc", busy_cnt, 25);
      ch_en = 2'b11;
      tick(4);

      // 5b: reset mid-window, then clean restart
      ce_n = 2'b10;
      observe(10, 5, 2'b11, 0, 2'b11);
      check("t5b_pre_setout", int'(setout), 1);
      check("t5b_pre_busy", int'(busy), 1);
      rst_n = 1'b0;
      #1;
      check("t5b_rst_setout", int'(setout), 0);
      check("t5b_rst_data_oe", int'(data_oe), 0);
      check("t5b_rst_ch_sel", int'(ch_sel), 0);
      check("t5b_rst_busy", int'(busy), 0);
      tick(2);
      rst_n = 1'b1;
      tick(5);
      ce_n = 2'b10;
      observe(35, 5, 2'b11, 0, 2'b11);
      check("t5b_re_rise_edge", rise_edge, 4);
      check("t5b_re_setout_cyc", set_cnt, 23);
      check("t5b_re_busy_cyc", busy_cnt, 25);
      tick(4);

`ifdef EMIF_DIR_STAT_EN
      // 6: statistics counter
      stat_clr = 1'b1;
      tick(1);
      stat_clr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         ce_n = 2'b10;
         observe(35, 5, 2'b11, 0, 2'b11);
         tick(4);
      end
      check("t6_rd_cnt3", int'(rd_cnt), 3);
      ce_n = 2'b10;
      tick(2);
      stat_clr = 1'b1;
      tick(3);
      stat_clr = 1'b0;
      check("t6_rise_seen", int'(setout), 1);
      check("t6_clr_wins", int'(rd_cnt), 0);
      ce_n = 2'b11;
      tick(30);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/emif_dir_ctrl.md
Name: emif_dir_ctrl

Overview:
- Parametrised EMIF data-bus direction controller; successor to the single-strobe read/out flag logic.
- Watches CH_NUM active-low chip-select/CAS strobes from the MCU, opens a hold window per access and drives the FPGA output enable while the MCU reads.
- Adds a bus turnaround guard, pending-access capture, overlap detection and a per-bit output-enable bus for the emif_data IOBUFs.
- Sits between the EMIF pad ring and the register-file read mux.

Parameters:
- CH_NUM, 2, number of strobe channels (1..8).
- SYNC_STAGES, 2, synchroniser depth for ce_n and we_logic (2..4).
- HOLD_CYC, 23, clk cycles the access window stays open (1..255).
- TURN_CYC, 2, forced bus-release cycles after each window (1..15).
- DW, 16, emif_data width driven by data_oe.

Ports:
- clk  in  1  system clock, 400 MHz.
- rst_n  in  1  asynchronous active-low reset.
- ce_n  in  CH_NUM  per-channel access strobes, active low, asynchronous to clk.
- ch_en  in  CH_NUM  channel enable mask; synchronous, static in normal use.
- we_logic  in  1  high = MCU read (FPGA drives), asynchronous.
- setout  out  1  FPGA drives emif_data, high active.
- data_oe  out  DW  registered replica of setout, one bit per data pin.
- ch_sel  out  CH_NUM  one-hot owner of the current window; 0 when idle.
- busy  out  1  high in any state other than IDLE.
- overlap_err  out  1  one-cycle pulse on a conflicting access.

Behaviour:
- Clock and reset:
  - One clock. Reset is asynchronous and active-low (rst_n). Clock port is clk.
  - Reset values: setout=0, data_oe=0, ch_sel=0, busy=0, overlap_err=0.
  - All synchroniser flops reset to 1 for ce_n and 0 for we_logic, so no spurious edge after reset.
  - Reset asserted mid-window drops all outputs immediately (async) and returns the FSM to IDLE.
- Synchroniser and edge detect:
  - Each ce_n bit and we_logic pass through SYNC_STAGES flops.
  - A falling edge is the last sync stage at 0 while one extra delay flop holds 1.
  - Edges on channels with ch_en=0 are ignored and do not raise overlap_err.
- Channel priority: when several enabled edges occur in the same cycle, the lowest index wins.
- FSM states:
  - IDLE:
    - Enabled edge -> ACTIVE; owner := winning channel; cnt := 1.
  - ACTIVE:
    - cnt increments each cycle.
    - Edge on the owner channel restarts cnt := 1 (retrigger).
    - Edge on any other enabled channel -> overlap_err pulses for 1 cycle; the edge is discarded.
    - When cnt == HOLD_CYC -> TURN with tcnt := 1.
  - TURN:
    - setout forced 0.
    - First enabled edge seen here is stored as pending (lowest index). Later edges in TURN pulse overlap_err.
    - When tcnt == TURN_CYC: if pending is set -> ACTIVE with owner := pending, cnt := 1, pending cleared; otherwise -> IDLE.
- Output rules:
  - setout is registered: setout <= (state==ACTIVE) & we_sync.
  - data_oe is registered in parallel with the same term; no extra delay vs setout.
  - A mid-window we_logic change follows through the synchroniser, so direction can switch within a window.
- Latency:
  - Given we_logic high at least SYNC_STAGES cycles beforehand, setout rises at rising edge SYNC_STAGES+2, counting the first edge that samples ce_n low as edge 1.
  - With defaults: edge 4.
- Window length:
  - ACTIVE lasts exactly HOLD_CYC cycles without retrigger.
  - setout high exactly HOLD_CYC cycles, delayed 1 cycle from ACTIVE.
- Status outputs:
  - ch_sel = one-hot owner in ACTIVE and TURN, 0 in IDLE.
  - busy = (state != IDLE).
- Counter widths: cnt is 8 bit; tcnt is 4 bit. Neither wraps, because FSM exits at the terminal value.

Optional Feature:
- Macro: EMIF_DIR_STAT_EN.
- When defined:
  - Adds input stat_clr (1) and output rd_cnt (16).
  - rd_cnt increments on every cycle where setout rises 0->1, saturating at 16'hFFFF.
  - stat_clr=1 clears it to 0; stat_clr wins over a simultaneous increment.
  - rd_cnt resets to 0.
- When undefined: neither port nor the counter exists; all other behaviour is identical.

Test Plan:
1. Defaults, we_logic=1 held, ce_n[0] falls once -> setout and all data_oe bits rise on edge 4, stay high 23 cycles; busy high 23+2 cycles; ch_sel=2'b01 throughout.
2. we_logic=0, ce_n[1] falls -> setout stays 0; busy high 25 cycles; ch_sel=2'b10.
3. ce_n[0] refalls 10 cycles into its window -> cnt restarts; setout high 10+23 cycles total, no overlap_err.
4. ce_n[1] falls during ch0 ACTIVE -> overlap_err one-cycle pulse; window unaffected. ce_n[1] falls during TURN instead -> ch1 window starts immediately after TURN_CYC=2, ch_sel goes 01 -> 10.
5. Both ce_n bits fall in the same cycle with ch_en=2'b10 -> only ch1 served; no overlap_err. rst_n pulled low mid-window -> all outputs 0 at once; clean restart after release.
6. EMIF_DIR_STAT_EN defined: 3 read accesses -> rd_cnt=3; stat_clr asserted in the same cycle as a 4th rise -> rd_cnt=0.
